// File: rtl/bw_io_impctl_snapreg.sv
// Impedance-code snapshot register: per-channel glitch filters, snapshot capture
// of filtered codes to the pad drivers, and a shadow-scan chain for freeze/override.
module bw_io_impctl_snapreg #(
  parameter int CODE_W = 8,
  parameter int NCH    = 2,
  parameter int FILT   = 2
) (
  input  logic                  clk,
  input  logic                  hard_reset_n,
  input  logic                  ctu_global_snap,
  input  logic [NCH*CODE_W-1:0] z,
  input  logic                  sscan_se,
  input  logic                  sscan_in,
  input  logic                  sscan_update,
  output logic                  sscan_out,
  output logic [NCH*CODE_W-1:0] sz,
  output logic                  snap_enable,
  output logic                  freeze,
  output logic [NCH-1:0]        code_stable
);

  localparam int         ZW      = NCH * CODE_W;
  localparam logic [3:0] CNT_MAX = 4'(FILT - 1);

  logic          snap_enable_q;
  logic          freeze_q;
  logic          freeze_d;
  logic [ZW:0]   chain_q;
  logic [ZW:0]   chain_d;
  logic          update_active;

  // An update strobe is ignored while shifting.
  assign update_active = !sscan_se && sscan_update;

  assign snap_enable = snap_enable_q;
  assign freeze      = freeze_q;
  assign sscan_out   = chain_q[0];

  always_ff @(posedge clk or negedge hard_reset_n) begin
    if (!hard_reset_n) begin
      snap_enable_q <= 1'b0;
    end else begin
      snap_enable_q <= ctu_global_snap;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [CODE_W-1:0] z_c;
      logic [CODE_W-1:0] zq_q;
      logic [CODE_W-1:0] zq_d;
      logic [3:0]        cnt_q;
      logic [3:0]        cnt_d;
      logic [CODE_W-1:0] sz_q;
      logic [CODE_W-1:0] sz_d;

      assign z_c = z[gi*CODE_W +: CODE_W];

      // Any change restarts the stability count; identical samples saturate it.
      always_comb begin
        zq_d  = zq_q;
        cnt_d = cnt_q;
        if (z_c != zq_q) begin
          zq_d  = z_c;
          cnt_d = 4'd0;
        end else if (cnt_q < CNT_MAX) begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      assign code_stable[gi] = (cnt_q == CNT_MAX);

      // Scan-update cycles never capture: a freeze=0 write must leave sz alone.
      always_comb begin
        sz_d = sz_q;
        if (update_active) begin
          if (chain_q[ZW]) begin
            sz_d = chain_q[gi*CODE_W +: CODE_W];
          end
        end else if (snap_enable_q && !freeze_q && code_stable[gi]) begin
          sz_d = zq_q;
        end
      end

      always_ff @(posedge clk or negedge hard_reset_n) begin
        if (!hard_reset_n) begin
          zq_q  <= '0;
          cnt_q <= 4'd0;
          sz_q  <= '0;
        end else begin
          zq_q  <= zq_d;
          cnt_q <= cnt_d;
          sz_q  <= sz_d;
        end
      end

      assign sz[gi*CODE_W +: CODE_W] = sz_q;
    end
  endgenerate

  always_comb begin
    chain_d  = chain_q;
    freeze_d = freeze_q;
    if (sscan_se) begin
      chain_d = {sscan_in, chain_q[ZW:1]};
    end else if (sscan_update) begin
      freeze_d = chain_q[ZW];
    end else begin
      chain_d = {freeze_q, sz};
    end
  end

  always_ff @(posedge clk or negedge hard_reset_n) begin
    if (!hard_reset_n) begin
      chain_q  <= '0;
      freeze_q <= 1'b0;
    end else begin
      chain_q  <= chain_d;
      freeze_q <= freeze_d;
    end
  end

endmodule

// File: tb/tb_bw_io_impctl_snapreg.sv
// Scoreboard bench for bw_io_impctl_snapreg (defaults CODE_W=8, NCH=2, FILT=2).
module tb_bw_io_impctl_snapreg;

  logic        clk = 1'b0;
  logic        hard_reset_n;
  logic        ctu_global_snap;
  logic [15:0] z;
  logic        sscan_se;
  logic        sscan_in;
  logic        sscan_update;
  logic        sscan_out;
  logic [15:0] sz;
  logic        snap_enable;
  logic        freeze;
  logic [1:0]  code_stable;

  bw_io_impctl_snapreg dut (
    .clk            (clk),
    .hard_reset_n   (hard_reset_n),
    .ctu_global_snap(ctu_global_snap),
    .z              (z),
    .sscan_se       (sscan_se),
    .sscan_in       (sscan_in),
    .sscan_update   (sscan_update),
    .sscan_out      (sscan_out),
    .sz             (sz),
    .snap_enable    (snap_enable),
    .freeze         (freeze),
    .code_stable    (code_stable)
  );

  always #5 clk = ~clk;

  localparam int K_SZ = 0, K_SNAP = 1, K_FRZ = 2, K_CS = 3, K_SOUT = 4;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [31:0] get_actual(input int kind);
    case (kind)
      K_SZ:    return {16'd0, sz};
      K_SNAP:  return {31'd0, snap_enable};
      K_FRZ:   return {31'd0, freeze};
      K_CS:    return {30'd0, code_stable};
      default: return {31'd0, sscan_out};
    endcase
  endfunction

  task automatic push_exp(input string name, input int kind, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.exp  = v;
    sb_q.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: drain all pending expectations mid-cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        exp_t e;
        logic [31:0] act;
        e   = sb_q.pop_front();
        act = get_actual(e.kind);
        n_checks++;
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got %h, required %h", e.name, act, e.exp);
        end else begin
          $display("ok   %s: %h", e.name, act);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic shift17(input logic [16:0] v);
    for (int k = 0; k < 17; k++) begin
      sscan_se = 1'b1;
      sscan_in = v[k];
      tick();
    end
    sscan_se = 1'b0;
    sscan_in = 1'b0;
  endtask

  logic [15:0] cs_tog [4];
  logic [15:0] sz_tog [4];
  logic [16:0] img;

  initial begin
    hard_reset_n    = 1'b0;
    ctu_global_snap = 1'b0;
    z               = 16'h0000;
    sscan_se        = 1'b0;
    sscan_in        = 1'b0;
    sscan_update    = 1'b0;

    // Reset state
    tick();
    tick();
    push_exp("rst_sz",   K_SZ,   32'h0);
    push_exp("rst_snap", K_SNAP, 32'h0);
    push_exp("rst_frz",  K_FRZ,  32'h0);
    push_exp("rst_cs",   K_CS,   32'h0);
    push_exp("rst_sout", K_SOUT, 32'h0);
    @(negedge clk);
    #1;

    // Basic capture: z settles during reset, snap held high
    z               = 16'h3C5A;
    ctu_global_snap = 1'b1;
    tick();
    hard_reset_n = 1'b1;
    tick();
    push_exp("cap_e1_snap", K_SNAP, 32'h1);
    push_exp("cap_e1_sz",   K_SZ,   32'h0);
    push_exp("cap_e1_cs",   K_CS,   32'h0);
    tick();
    push_exp("cap_e2_cs",   K_CS,   32'h3);
    push_exp("cap_e2_sz",   K_SZ,   32'h0);
    tick();
    push_exp("cap_e3_sz",   K_SZ,   32'h3C5A);

    // Channel 0 toggling, channel 1 moves to 0x77
    cs_tog[0] = 16'h0; sz_tog[0] = 16'h3C5A;
    cs_tog[1] = 16'h2; sz_tog[1] = 16'h3C5A;
    cs_tog[2] = 16'h2; sz_tog[2] = 16'h775A;
    cs_tog[3] = 16'h2; sz_tog[3] = 16'h775A;
    for (int i = 0; i < 4; i++) begin
      z = {8'h77, (i % 2 == 0) ? 8'h11 : 8'h22};
      tick();
      push_exp($sformatf("tog%0d_cs", i), K_CS, {16'd0, cs_tog[i]});
      push_exp($sformatf("tog%0d_sz", i), K_SZ, {16'd0, sz_tog[i]});
    end
    tick();
    push_exp("settle_cs", K_CS, 32'h3);
    tick();
    push_exp("settle_sz", K_SZ, 32'h7722);

    // Scan override with freeze=1
    shift17(17'h1A5C3);
    push_exp("ovr_sout", K_SOUT, 32'h1);
    sscan_update = 1'b1;
    tick();
    sscan_update = 1'b0;
    push_exp("ovr_frz", K_FRZ, 32'h1);
    push_exp("ovr_sz",  K_SZ,  32'hA5C3);
    z = 16'h1234;
    tick();
    tick();
    push_exp("frz_cs_runs", K_CS, 32'h3);
    tick();
    push_exp("frz_sz_hold", K_SZ,  32'hA5C3);
    push_exp("frz_still",   K_FRZ, 32'h1);

    // Shift and update together: shift wins
    sscan_se     = 1'b1;
    sscan_update = 1'b1;
    sscan_in     = 1'b0;
    tick();
    tick();
    push_exp("both_sout", K_SOUT, 32'h0);
    push_exp("both_frz",  K_FRZ,  32'h1);
    push_exp("both_sz",   K_SZ,   32'hA5C3);
    sscan_se     = 1'b0;
    sscan_update = 1'b0;

    // One parallel load, then unload the image LSB first
    img = 17'h1A5C3;
    tick();
    push_exp("unload_b0", K_SOUT, {31'd0, img[0]});
    for (int k = 1; k < 17; k++) begin
      sscan_se = 1'b1;
      sscan_in = 1'b0;
      tick();
      push_exp($sformatf("unload_b%0d", k), K_SOUT, {31'd0, img[k]});
    end
    sscan_se = 1'b0;

    // Unfreeze via scan: sz untouched, capture resumes next cycle
    shift17(17'h0FFFF);
    sscan_update = 1'b1;
    tick();
    sscan_update = 1'b0;
    push_exp("unfrz_frz", K_FRZ, 32'h0);
    push_exp("unfrz_sz",  K_SZ,  32'hA5C3);
    tick();
    push_exp("resume_sz", K_SZ,  32'h1234);

    // Asynchronous reset mid-operation
    z = 16'hABCD;
    tick();
    #2;
    hard_reset_n = 1'b0;
    #1;
    push_exp("arst_sz",   K_SZ,   32'h0);
    push_exp("arst_snap", K_SNAP, 32'h0);
    push_exp("arst_frz",  K_FRZ,  32'h0);
    push_exp("arst_cs",   K_CS,   32'h0);
    push_exp("arst_sout", K_SOUT, 32'h0);
    tick();
    hard_reset_n = 1'b1;
    tick();
    push_exp("rel_e1_sz", K_SZ, 32'h0);
    tick();
    push_exp("rel_e2_sz", K_SZ, 32'h0);
    push_exp("rel_e2_cs", K_CS, 32'h3);
    tick();
    push_exp("rel_e3_sz", K_SZ, 32'hABCD);

    tick();
    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
